// File: rtl/riscv_wb_pkg.sv
// ---------------------------------------------------------------------------
// riscv_wb_pkg
// Shared types and constants for the RV12 write-back stage:
//   - instruction_t / interrupts_exceptions_t pipeline payloads
//   - wb_state_t write-back FSM encoding
//   - major opcodes (instr[6:2]) and load funct3 codes
//   - exception cause bit positions raised by the load path
// ---------------------------------------------------------------------------
package riscv_wb_pkg;

   localparam int ILEN  = 32;
   localparam int EXC_W = 16;

   typedef struct packed {
      logic            bubble;
      logic [ILEN-1:0] instr;
   } instruction_t;

   typedef struct packed {
      logic             any;
      logic [EXC_W-1:0] cause;
   } interrupts_exceptions_t;

   typedef enum logic {RUN, LOAD_WAIT} wb_state_t;

   // Exception cause bit positions (RISC-V mcause numbering)
   localparam int CAUSE_MISALIGNED_LOAD   = 4;
   localparam int CAUSE_LOAD_ACCESS_FAULT = 5;
   localparam int CAUSE_LOAD_PAGE_FAULT   = 13;

   // Major opcodes, instr[6:2]
   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_OP32     = 5'b01110;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   // Load funct3
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   // Opcodes whose instructions produce a register-file result
   function automatic logic writes_rd(input logic [4:0] opc);
      case (opc)
         OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM32, OPC_OP,
         OPC_LUI, OPC_OP32, OPC_JALR, OPC_JAL, OPC_SYSTEM: writes_rd = 1'b1;
         default:                                          writes_rd = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_wb_ldalign.sv
// ---------------------------------------------------------------------------
// riscv_wb_ldalign
// Combinational load-data aligner: shifts the raw bus word down to the
// addressed byte lane, sign/zero-extends by funct3, and flags misaligned
// accesses. With XLEN=32, LD and LWU behave as LW.
// Ports:
//   i_funct3      load funct3
//   i_adr         low address bits selecting the byte lane
//   i_q           raw load data from dmem
//   o_data        aligned and extended load result
//   o_misaligned  access not naturally aligned for its size
// ---------------------------------------------------------------------------
module riscv_wb_ldalign
   import riscv_wb_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int SB   = $clog2(XLEN/8)
) (
   input  logic [2:0]      i_funct3,
   input  logic [SB-1:0]   i_adr,
   input  logic [XLEN-1:0] i_q,
   output logic [XLEN-1:0] o_data,
   output logic            o_misaligned
);

   logic [XLEN-1:0] w_sh;

   assign w_sh = i_q >> {i_adr, 3'b000};

   always_comb begin
      o_data       = w_sh;
      o_misaligned = 1'b0;
      case (i_funct3)
         LB:  o_data = XLEN'($signed(w_sh[7:0]));
         LBU: o_data = XLEN'(w_sh[7:0]);
         LH:  begin
            o_data       = XLEN'($signed(w_sh[15:0]));
            o_misaligned = i_adr[0];
         end
         LHU: begin
            o_data       = XLEN'(w_sh[15:0]);
            o_misaligned = i_adr[0];
         end
         LW:  begin
            o_data       = XLEN'($signed(w_sh[31:0]));
            o_misaligned = |i_adr[1:0];
         end
         LWU: begin
            // on RV32 this is a full-width word, identical to LW
            o_data       = XLEN'(w_sh[31:0]);
            o_misaligned = |i_adr[1:0];
         end
         // On RV32 i_adr is 2 bits wide, so LD checks word alignment like LW
         LD:  o_misaligned = |i_adr;
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_wb.sv
// ---------------------------------------------------------------------------
// riscv_wb
// RV12 write-back stage. Registers the MEM-stage result, terminates loads
// (waits for dmem response, aligns/extends data, raises load faults), drives
// the register-file write port and the committed exception vector, and
// stalls all upstream stages while a load is outstanding.
// Optional feature: define RV12_WB_LOAD_TIMEOUT_EN to add a load-wait
// watchdog that raises a load access fault after LOAD_TIMEOUT stall cycles.
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   wb_stall_o                 stall to MEM/EX/ID/IF (combinational)
//   mem_*_i                    MEM-stage pc/instr/exceptions/result/address
//   dmem_ack_i/err_i/page_fault_i/q_i  data-memory load response
//   wb_pc_o/insn_o/exceptions_o/badaddr_o  committed instruction state
//   wb_we_o/dst_o/r_o          register-file write port
// ---------------------------------------------------------------------------
module riscv_wb
   import riscv_wb_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] PC_INIT      = 'h200,
   parameter int              LOAD_TIMEOUT = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   output logic                   wb_stall_o,
   input  logic [XLEN-1:0]        mem_pc_i,
   input  instruction_t           mem_insn_i,
   input  interrupts_exceptions_t mem_exceptions_i,
   input  logic [XLEN-1:0]        mem_r_i,
   input  logic [XLEN-1:0]        mem_memadr_i,
   input  logic                   dmem_ack_i,
   input  logic                   dmem_err_i,
   input  logic                   dmem_page_fault_i,
   input  logic [XLEN-1:0]        dmem_q_i,
   output logic [XLEN-1:0]        wb_pc_o,
   output instruction_t           wb_insn_o,
   output interrupts_exceptions_t wb_exceptions_o,
   output logic [XLEN-1:0]        wb_badaddr_o,
   output logic                   wb_we_o,
   output logic [4:0]             wb_dst_o,
   output logic [XLEN-1:0]        wb_r_o
);

   localparam int SB = $clog2(XLEN/8);

   if ((XLEN != 32 && XLEN != 64) || LOAD_TIMEOUT < 1) begin : g_bad_cfg
      $error("riscv_wb: unsupported XLEN or LOAD_TIMEOUT");
   end

   wb_state_t              r_state, w_nxt;
   logic [XLEN-1:0]        r_pc, r_r, r_badaddr;
   instruction_t           r_insn;
   interrupts_exceptions_t r_exc;
   logic                   r_we;
   logic [4:0]             r_dst;

   logic [4:0]       w_opc, w_rd;
   logic             w_is_load, w_load_act, w_misal, w_stall, w_timeout;
   logic [XLEN-1:0]  w_ld_data;
   logic [EXC_W-1:0] w_ld_cause;
   logic             w_ld_fault;

   assign w_opc = mem_insn_i.instr[6:2];
   assign w_rd  = mem_insn_i.instr[11:7];

   assign w_is_load  = !mem_insn_i.bubble && (w_opc == OPC_LOAD);
   // A load already carrying an exception, or arriving while the stage is
   // flushing, never touches the bus
   assign w_load_act = w_is_load && !mem_exceptions_i.any && !r_exc.any;

   riscv_wb_ldalign #(.XLEN(XLEN)) u_ldalign (
      .i_funct3     (mem_insn_i.instr[14:12]),
      .i_adr        (mem_memadr_i[SB-1:0]),
      .i_q          (dmem_q_i),
      .o_data       (w_ld_data),
      .o_misaligned (w_misal)
   );

   // Gated by reset so upstream stages are released while reset is held
   assign w_stall = rst_ni && w_load_act && !w_misal && !dmem_ack_i &&
                    !dmem_err_i && !dmem_page_fault_i && !w_timeout;

`ifdef RV12_WB_LOAD_TIMEOUT_EN
   localparam int CW = $clog2(LOAD_TIMEOUT + 1);
   logic [CW-1:0] r_cnt;

   // r_cnt equals the number of stall cycles already spent on the load, so
   // the stall lasts exactly LOAD_TIMEOUT cycles
   always_ff @(posedge clk_i) begin
      if (!rst_ni || w_nxt == RUN) r_cnt <= '0;
      else if (r_state == RUN)     r_cnt <= CW'(1);
      else                         r_cnt <= r_cnt + 1'b1;
   end

   assign w_timeout = (r_state == LOAD_WAIT) && (r_cnt >= CW'(LOAD_TIMEOUT));
`else
   assign w_timeout = 1'b0;
`endif

   // Load fault priority: misaligned > page fault > access fault.
   // Any fault overrides a coincident ack.
   always_comb begin
      w_ld_cause = '0;
      if (w_load_act && !w_stall) begin
         if (w_misal)                       w_ld_cause[CAUSE_MISALIGNED_LOAD]   = 1'b1;
         else if (dmem_page_fault_i)        w_ld_cause[CAUSE_LOAD_PAGE_FAULT]   = 1'b1;
         else if (dmem_err_i || w_timeout)  w_ld_cause[CAUSE_LOAD_ACCESS_FAULT] = 1'b1;
      end
   end

   assign w_ld_fault = |w_ld_cause;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= RUN;
      else         r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         RUN:       if (w_stall)  w_nxt = LOAD_WAIT;
         LOAD_WAIT: if (!w_stall) w_nxt = RUN;
         default:                 w_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_pc        <= PC_INIT;
         r_insn      <= '{bubble: 1'b1, instr: '0};
         r_exc       <= '0;
         r_we        <= 1'b0;
         r_dst       <= '0;
         r_r         <= '0;
         r_badaddr   <= '0;
      end else begin
         // Stalled cycles and the flush cycle after an exception commit
         // nothing, preventing a double write-back
         r_insn.bubble <= w_stall || r_exc.any || mem_insn_i.bubble;
         r_we          <= !w_stall && !r_exc.any && !mem_insn_i.bubble &&
                          writes_rd(w_opc) && (w_rd != 5'd0) &&
                          !mem_exceptions_i.any && !w_ld_fault;

         if (r_exc.any || w_stall) r_exc <= '0;
         else begin
            r_exc.any   <= mem_exceptions_i.any | w_ld_fault;
            r_exc.cause <= mem_exceptions_i.cause | w_ld_cause;
         end

         if (!w_stall) begin
            r_pc         <= mem_pc_i;
            r_insn.instr <= mem_insn_i.instr;
            r_dst        <= w_rd;
            r_r          <= w_is_load ? w_ld_data : mem_r_i;
         end

         if (w_ld_fault) r_badaddr <= mem_memadr_i;
      end
   end

   assign wb_stall_o      = w_stall;
   assign wb_pc_o         = r_pc;
   assign wb_insn_o       = r_insn;
   assign wb_exceptions_o = r_exc;
   assign wb_badaddr_o    = r_badaddr;
   assign wb_we_o         = r_we;
   assign wb_dst_o        = r_dst;
   assign wb_r_o          = r_r;

endmodule

// File: tb/tb_riscv_wb.sv
// ---------------------------------------------------------------------------
// tb_riscv_wb
// Self-checking bench for riscv_wb (XLEN=32, LOAD_TIMEOUT=4): directed
// scenarios followed by randomized instruction streams, compared against a
// behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_riscv_wb;
   import riscv_wb_pkg::*;

`ifdef RV12_WB_LOAD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TO_LIM = 4;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic                   rst_ni;
   logic                   wb_stall_o;
   logic [31:0]            mem_pc_i, mem_r_i, mem_memadr_i, dmem_q_i;
   instruction_t           mem_insn_i;
   interrupts_exceptions_t mem_exceptions_i;
   logic                   dmem_ack_i, dmem_err_i, dmem_page_fault_i;
   logic [31:0]            wb_pc_o, wb_badaddr_o, wb_r_o;
   instruction_t           wb_insn_o;
   interrupts_exceptions_t wb_exceptions_o;
   logic                   wb_we_o;
   logic [4:0]             wb_dst_o;

   riscv_wb #(.XLEN(32), .PC_INIT(32'h200), .LOAD_TIMEOUT(TO_LIM)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .wb_stall_o(wb_stall_o),
      .mem_pc_i(mem_pc_i), .mem_insn_i(mem_insn_i),
      .mem_exceptions_i(mem_exceptions_i), .mem_r_i(mem_r_i),
      .mem_memadr_i(mem_memadr_i), .dmem_ack_i(dmem_ack_i),
      .dmem_err_i(dmem_err_i), .dmem_page_fault_i(dmem_page_fault_i),
      .dmem_q_i(dmem_q_i), .wb_pc_o(wb_pc_o), .wb_insn_o(wb_insn_o),
      .wb_exceptions_o(wb_exceptions_o), .wb_badaddr_o(wb_badaddr_o),
      .wb_we_o(wb_we_o), .wb_dst_o(wb_dst_o), .wb_r_o(wb_r_o)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pc, m_bad, m_r;
   logic [4:0]  m_dst;
   logic        m_bub, m_we;
   logic [16:0] m_exc;      // {any, cause}
   int          m_wait;

   function automatic int ld_size(input logic [2:0] f3);
      if (f3[1:0] == 2'd0)      return 1;
      else if (f3[1:0] == 2'd1) return 2;
      else                      return 4;   // LW/LD/LWU are all words on RV32
   endfunction

   function automatic logic [31:0] ld_ref(input logic [2:0] f3, input logic [31:0] adr,
                                          input logic [31:0] q);
      longint v, full;
      int sh;
      sh   = 8 * int'(adr[1:0]);
      v    = {32'b0, q >> sh};
      full = longint'(1) << (8 * ld_size(f3));
      v    = v % full;
      if ((f3 == 3'd0 || f3 == 3'd1) && v >= full / 2) v = v - full;
      return v[31:0];
   endfunction

   function automatic bit wr_rd(input logic [4:0] opc);
      return opc == 5'b00000 || opc == 5'b00100 || opc == 5'b01100 || opc == 5'b01101;
   endfunction

   function automatic logic [31:0] mk(input logic [4:0] opc, input logic [2:0] f3,
                                      input logic [4:0] rd);
      logic [31:0] x;
      x = $urandom();
      return {x[31:15], f3, rd, opc, 2'b11};
   endfunction

   // One clock with the current MEM/dmem inputs; entered and left at negedge
   task automatic step(output bit stl);
      logic [4:0]  opc, rd;
      logic [2:0]  f3;
      logic [15:0] cause;
      bit ld, act, mis, to, stall, fault, old_any;
      #1;
      opc     = mem_insn_i.instr[6:2];
      rd      = mem_insn_i.instr[11:7];
      f3      = mem_insn_i.instr[14:12];
      old_any = m_exc[16];
      ld      = !mem_insn_i.bubble && opc == 5'b00000;
      act     = ld && !mem_exceptions_i.any && !old_any;
      mis     = (mem_memadr_i % ld_size(f3)) != 0;
      to      = TO_EN && m_wait >= TO_LIM;
      stall   = act && !mis && !dmem_ack_i && !dmem_err_i && !dmem_page_fault_i && !to;
      chk("stall", wb_stall_o, stall);
      cause = '0;
      if (act && !stall) begin
         if (mis)                         cause[CAUSE_MISALIGNED_LOAD]   = 1'b1;
         else if (dmem_page_fault_i)      cause[CAUSE_LOAD_PAGE_FAULT]   = 1'b1;
         else if (dmem_err_i || to)       cause[CAUSE_LOAD_ACCESS_FAULT] = 1'b1;
      end
      fault = cause != 0;
      m_bub = stall || old_any || mem_insn_i.bubble;
      m_we  = !stall && !old_any && !mem_insn_i.bubble && wr_rd(opc) && rd != 0 &&
              !mem_exceptions_i.any && !fault;
      m_exc = (old_any || stall) ? 17'd0
              : {mem_exceptions_i.any | fault, mem_exceptions_i.cause | cause};
      if (!stall) m_pc = mem_pc_i;
      if (m_we) begin
         m_r   = ld ? ld_ref(f3, mem_memadr_i, dmem_q_i) : mem_r_i;
         m_dst = rd;
      end
      if (fault) m_bad = mem_memadr_i;
      m_wait = stall ? m_wait + 1 : 0;
      @(posedge clk_i); #1;
      chk("pc", wb_pc_o, m_pc);
      chk("bubble", wb_insn_o.bubble, m_bub);
      chk("we", wb_we_o, m_we);
      chk("exc", wb_exceptions_o, m_exc);
      chk("badaddr", wb_badaddr_o, m_bad);
      if (m_we) begin
         chk("wb_r", wb_r_o, m_r);
         chk("dst", wb_dst_o, m_dst);
      end
      @(negedge clk_i);
      stl = stall;
   endtask

   task automatic idle_inputs();
      mem_insn_i        = '{bubble: 1'b1, instr: 32'h13};
      mem_exceptions_i  = '0;
      mem_pc_i          = '0;
      mem_r_i           = '0;
      mem_memadr_i      = '0;
      dmem_q_i          = '0;
      dmem_ack_i        = 1'b0;
      dmem_err_i        = 1'b0;
      dmem_page_fault_i = 1'b0;
   endtask

   // Reset with whatever MEM inputs are present; entered and left at negedge
   task automatic do_reset();
      rst_ni = 1'b0;
      #1 chk("rst_stall", wb_stall_o, 1'b0);
      @(posedge clk_i); #1;
      chk("rst_pc", wb_pc_o, 32'h200);
      chk("rst_bubble", wb_insn_o.bubble, 1'b1);
      chk("rst_we", wb_we_o, 1'b0);
      chk("rst_exc", wb_exceptions_o, 17'd0);
      chk("rst_r", wb_r_o, 32'd0);
      chk("rst_dst", wb_dst_o, 5'd0);
      chk("rst_badaddr", wb_badaddr_o, 32'd0);
      m_pc = 32'h200; m_bad = '0; m_r = '0; m_dst = '0;
      m_bub = 1'b1; m_we = 1'b0; m_exc = '0; m_wait = 0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle_inputs();
   endtask

   // resp: 0 ack, 1 err, 2 page fault, 3 ack+err, 4 ack+pf, 5 none
   task automatic run_insn(input logic [31:0] ins, input bit bub, input logic [31:0] adr,
                           input logic [31:0] q, input int lat, input int resp,
                           input bit mexc, output int nstall);
      bit s;
      bit done;
      nstall = 0;
      done   = 1'b0;
      mem_insn_i       = '{bubble: bub, instr: ins};
      mem_exceptions_i = '{any: mexc, cause: mexc ? 16'h0004 : 16'h0};
      mem_pc_i         = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      mem_r_i          = $urandom();
      mem_memadr_i     = adr;
      dmem_q_i         = q;
      for (int k = 0; k < 20 && !done; k++) begin
         dmem_ack_i        = (k == lat) && (resp == 0 || resp == 3 || resp == 4);
         dmem_err_i        = (k == lat) && (resp == 1 || resp == 3);
         dmem_page_fault_i = (k == lat) && (resp == 2 || resp == 4);
         step(s);
         if (s) nstall++;
         else   done = 1'b1;
      end
      if (!done) chk("load_wait_bound", 1'b1, 1'b0);
      dmem_ack_i = 1'b0; dmem_err_i = 1'b0; dmem_page_fault_i = 1'b0;
   endtask

   task automatic bubble_cycle();
      int ns;
      run_insn(32'h13, 1'b1, 32'h0, 32'h0, 0, 5, 1'b0, ns);
   endtask

   initial begin
      int ns;
      bit s;
      idle_inputs();
      @(negedge clk_i);
      do_reset();

      // LW, ack after 3 cycles
      run_insn(mk(5'b00000, LW, 5'd5), 1'b0, 32'h1000, 32'h8000_00FF, 3, 0, 1'b0, ns);
      chk("lw_stall_cycles", ns, 3);
      chk("lw_data", wb_r_o, 32'h8000_00FF);
      chk("lw_we", wb_we_o, 1'b1);
      bubble_cycle();
      chk("lw_we_pulse", wb_we_o, 1'b0);

      // byte loads from the top lane
      run_insn(mk(5'b00000, LB, 5'd6), 1'b0, 32'h1003, 32'h80AA_BBCC, 0, 0, 1'b0, ns);
      chk("lb_data", wb_r_o, 32'hFFFF_FF80);
      run_insn(mk(5'b00000, LBU, 5'd6), 1'b0, 32'h1003, 32'h80AA_BBCC, 1, 0, 1'b0, ns);
      chk("lbu_data", wb_r_o, 32'h0000_0080);

      // misaligned halfword
      run_insn(mk(5'b00000, LH, 5'd7), 1'b0, 32'h1001, 32'h1234_5678, 2, 0, 1'b0, ns);
      chk("lh_mis_nostall", ns, 0);
      chk("lh_mis_cause", wb_exceptions_o, {1'b1, 16'h0010});
      chk("lh_mis_badaddr", wb_badaddr_o, 32'h1001);
      chk("lh_mis_we", wb_we_o, 1'b0);
      bubble_cycle();

      // ack together with err: fault wins, then flush
      run_insn(mk(5'b00000, LW, 5'd8), 1'b0, 32'h2004, 32'hDEAD_BEEF, 1, 3, 1'b0, ns);
      chk("ackerr_stall", ns, 1);
      chk("ackerr_cause", wb_exceptions_o, {1'b1, 16'h0020});
      chk("ackerr_we", wb_we_o, 1'b0);
      run_insn(mk(5'b01100, 3'd0, 5'd7), 1'b0, 32'h0, 32'h0, 0, 5, 1'b0, ns);
      chk("flush_bubble", wb_insn_o.bubble, 1'b1);
      chk("flush_exc_clr", wb_exceptions_o.any, 1'b0);

      // reset in LOAD_WAIT
      mem_insn_i   = '{bubble: 1'b0, instr: mk(5'b00000, LW, 5'd9)};
      mem_memadr_i = 32'h1000;
      mem_pc_i     = 32'h4000;
      step(s);
      step(s);
      chk("pre_rst_stall", wb_stall_o, 1'b1);
      do_reset();

      if (TO_EN) begin
         run_insn(mk(5'b00000, LW, 5'd10), 1'b0, 32'h3000, 32'h0, 0, 5, 1'b0, ns);
         chk("timeout_stall", ns, TO_LIM);
         chk("timeout_cause", wb_exceptions_o, {1'b1, 16'h0020});
         bubble_cycle();
      end

      // randomized stream
      for (int n = 0; n < 300; n++) begin
         int kind, lat, resp, r;
         logic [4:0]  opc;
         logic [2:0]  f3;
         logic [31:0] adr;
         kind = $urandom_range(0, 9);
         f3   = 3'($urandom_range(0, 6));
         case (kind)
            0, 1, 2, 3, 4: opc = 5'b00000;
            5:             opc = 5'b01000;
            6:             opc = 5'b01100;
            7:             opc = 5'b00100;
            8:             opc = 5'b01101;
            default:       opc = 5'b11000;
         endcase
         adr = $urandom();
         if ($urandom_range(0, 1) == 1) adr[2:0] = 3'd0;
         lat = $urandom_range(0, 3);
         r   = $urandom_range(0, TO_EN ? 9 : 8);
         resp = (r < 5) ? 0 : r - 4;
         run_insn(mk(opc, f3, 5'($urandom_range(0, 31))), $urandom_range(0, 9) == 0,
                  adr, $urandom(), lat, resp, $urandom_range(0, 11) == 0, ns);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
